// File: rtl/alu_host_sequencer_pkg.sv
// Shared definitions for the ALU host sequencer.
//   - op_code constants driven onto the control unit's op_code input
//   - host FSM state encoding
//   - words_per_op(): number of operand words streamed onto INBUS per op
package alu_host_sequencer_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } host_state_e;

  // Divide needs a double-width dividend (A:Q) plus the divisor; all other
  // ops load one operand register plus M.
  function automatic logic [1:0] words_per_op(input logic [1:0] op);
    return (op == OP_DIV) ? 2'd3 : 2'd2;
  endfunction

endpackage

// File: rtl/alu_watchdog_counter.sv
// Watchdog counter for the host sequencer's WAIT state.
// Ports:
//   clk         in   clock, rising edge
//   reset_input in   asynchronous active-high reset
//   clear_i     in   synchronous clear to zero (has priority over enable_i)
//   enable_i    in   count up by one per cycle; holds at terminal count
//   tc_o        out  high while the count equals TIMEOUT-1
module alu_watchdog_counter #(
  parameter int TIMEOUT = 64,
  parameter int TCNT_W  = 7
) (
  input  logic clk,
  input  logic reset_input,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam logic [TCNT_W-1:0] TC_VAL = TCNT_W'(TIMEOUT - 1);

  logic [TCNT_W-1:0] count_q, count_d;

  assign tc_o = (count_q == TC_VAL);

  // NOTE: every signal assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !tc_o) begin
      count_d = count_q + TCNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset_input) begin
    if (reset_input) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_host_sequencer.sv
// Host-side driver for the ALU control unit's BEGIN/INBUS/OUTBUS/END protocol.
// Accepts one request (valid/ready), pulses BEGIN, streams the operand words,
// captures the A/Q words pushed back on OUTBUS and returns them as a response.
// A watchdog aborts the ALU and flags an error if END never arrives.
// Ports:
//   clk, reset_input                clock / async active-high reset
//   req_valid/req_ready             request handshake; req_ready only in IDLE
//   req_op, req_a, req_q, req_m     operation and operand words
//   alu_begin, alu_op, alu_inbus    BEGIN, op_code and INBUS to control unit
//   alu_push_a/q, alu_outbus        OUTBUS capture strobes and data
//   alu_end                         END from control unit
//   alu_abort                       one-cycle ALU reset pulse on watchdog expiry
//   rsp_valid/rsp_ready             response handshake
//   rsp_hi, rsp_lo, rsp_error       captured A word, Q word, watchdog error
module alu_host_sequencer
  import alu_host_sequencer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int TCNT_W  = 7
) (
  input  logic             clk,
  input  logic             reset_input,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_q,
  input  logic [WIDTH-1:0] req_m,
  output logic             alu_begin,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_inbus,
  input  logic             alu_push_a,
  input  logic             alu_push_q,
  input  logic [WIDTH-1:0] alu_outbus,
  input  logic             alu_end,
  output logic             alu_abort,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic             rsp_error
);

  host_state_e      state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, q_q, q_d, m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [1:0]       idx_q, idx_d;
  logic             err_q, err_d;
  logic             abort_q, abort_d;
  logic             wd_tc;

  // The counter sits at zero outside WAIT, so it restarts on every WAIT entry.
  alu_watchdog_counter #(
    .TIMEOUT (TIMEOUT),
    .TCNT_W  (TCNT_W)
  ) u_watchdog (
    .clk         (clk),
    .reset_input (reset_input),
    .clear_i     (state_q != ST_WAIT),
    .enable_i    (state_q == ST_WAIT),
    .tc_o        (wd_tc)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    idx_d   = idx_q;
    err_d   = err_q;
    abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          q_d     = req_q;
          m_d     = req_m;
          hi_d    = '0;
          lo_d    = '0;
          err_d   = 1'b0;
          idx_d   = 2'd0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (idx_q == words_per_op(op_q) - 2'd1) begin
          idx_d   = 2'd0;
          state_d = ST_WAIT;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      ST_WAIT: begin
        // Push order varies by op; each strobe simply loads its own register.
        if (alu_push_a) hi_d = alu_outbus;
        if (alu_push_q) lo_d = alu_outbus;
        // END in the expiry cycle takes priority over the watchdog.
        if (alu_end) begin
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (wd_tc) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_input) begin
    if (reset_input) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  // INBUS word order follows the control unit's load sequence per op.
  always_comb begin
    alu_inbus = '0;
    if (state_q == ST_SEND) begin
      case (op_q)
        OP_MUL:  alu_inbus = (idx_q == 2'd0) ? q_q : m_q;
        OP_DIV: begin
          case (idx_q)
            2'd0:    alu_inbus = a_q;
            2'd1:    alu_inbus = q_q;
            default: alu_inbus = m_q;
          endcase
        end
        default: alu_inbus = (idx_q == 2'd0) ? a_q : m_q;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign alu_begin = (state_q == ST_SEND) && (idx_q == 2'd0);
  assign alu_op    = op_q;
  assign alu_abort = abort_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_hi    = hi_q;
  assign rsp_lo    = lo_q;
  assign rsp_error = err_q;

endmodule
